// File: rtl/mux_2_to_1.sv
// -----------------------------------------------------------------------------
// mux_2_to_1
//
// Registered 4-bit ALU for the CPU core datapath. Sel picks one of four
// operations on two unsigned 4-bit operands; the result and a flag bit are
// captured on every rising clk edge (one-cycle latency, one op per cycle,
// no handshake).
//
// Ports:
//   clk   in   1   system clock, rising-edge active
//   rst   in   1   asynchronous active-high reset, clears out/cout
//   A     in   4   operand A, unsigned
//   B     in   4   operand B, unsigned
//   Sel   in   2   00 add, 01 subtract, 10 multiply, 11 divide
//   out   out  16  registered result, unused upper bits zero
//   cout  out  1   registered carry / borrow / divide-by-zero flag
// -----------------------------------------------------------------------------
module mux_2_to_1 (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  A,
   input  logic [3:0]  B,
   input  logic [1:0]  Sel,
   output logic [15:0] out,
   output logic        cout
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   logic [4:0]  sum;
   logic [3:0]  diff;
   logic [7:0]  prod;
   logic [3:0]  quot;
   logic [3:0]  rem;
   logic        div_zero;

   logic [15:0] next_out;
   logic        next_cout;

   // Arithmetic kernels, all evaluated in parallel; Sel only steers the result.
   assign sum      = {1'b0, A} + {1'b0, B};
   assign diff     = A - B;                     // wraps mod 16
   assign prod     = {4'b0, A} * {4'b0, B};
   assign div_zero = (B == 4'd0);
   // The divider is fed a safe divisor of 1 when B is zero so it never sees a
   // zero divisor; its outputs are ignored in that case anyway.
   assign quot     = A / (div_zero ? 4'd1 : B);
   assign rem      = A % (div_zero ? 4'd1 : B);

   // NOTE: every output of this block is assigned a default before the case,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      next_out  = 16'h0000;
      next_cout = 1'b0;
      unique case (op_e'(Sel))
         OP_ADD: begin
            next_out  = {12'h000, sum[3:0]};
            next_cout = sum[4];
         end
         OP_SUB: begin
            next_out  = {12'h000, diff};
            next_cout = (A < B);                 // borrow
         end
         OP_MUL: begin
            next_out  = {8'h00, prod};
         end
         OP_DIV: begin
            if (div_zero) begin
               // Error result: dividend echoed in the remainder slot, all-ones quotient.
               next_out  = {4'h0, A, 4'h0, 4'hF};
               next_cout = 1'b1;
            end else begin
               next_out  = {4'h0, rem, 4'h0, quot};
            end
         end
         default: begin
            next_out  = 16'h0000;
            next_cout = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out  <= 16'h0000;
         cout <= 1'b0;
      end else begin
         out  <= next_out;
         cout <= next_cout;
      end
   end

endmodule

// File: tb/tb_mux_2_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux_2_to_1
//
// Directed bench for mux_2_to_1: reset, each operation with hand-computed
// results, divide-by-zero, one-edge latency, mid-cycle input changes and an
// asynchronous reset pulse between edges.
// -----------------------------------------------------------------------------
module tb_mux_2_to_1;

   logic        clk;
   logic        rst;
   logic [3:0]  A;
   logic [3:0]  B;
   logic [1:0]  Sel;
   logic [15:0] out;
   logic        cout;

   int n_checks = 0;
   int n_fail   = 0;

   mux_2_to_1 dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .Sel  (Sel),
      .out  (out),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] exp_out, input logic exp_cout);
      n_checks++;
      assert (out === exp_out) else begin
         n_fail++;
         $error("FAIL %s out: observed %h expected %h", tag, out, exp_out);
      end
      n_checks++;
      assert (cout === exp_cout) else begin
         n_fail++;
         $error("FAIL %s cout: observed %b expected %b", tag, cout, exp_cout);
      end
   endtask

   // Drive operands, wait one rising edge, sample 1 time unit later.
   task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                       input logic [15:0] exp_out, input logic exp_cout, input string tag);
      A   = a;
      B   = b;
      Sel = sel;
      @(posedge clk);
      #1;
      check(tag, exp_out, exp_cout);
   endtask

   initial begin
      rst = 1'b1;
      A   = 4'd9;
      B   = 4'd3;
      Sel = 2'b10;

      // Reset held across several edges
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", 16'h0000, 1'b0);

      // Release away from the edge; first capture on the next edge
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_release_mul", 16'd27, 1'b0);

      // Add
      step(4'd1,  4'd2,  2'b00, 16'd3,  1'b0, "add_1_2");
      step(4'd15, 4'd15, 2'b00, 16'd14, 1'b1, "add_15_15");
      step(4'd7,  4'd9,  2'b00, 16'd0,  1'b1, "add_7_9");

      // Subtract
      step(4'd3,  4'd4,  2'b01, 16'd15, 1'b1, "sub_3_4");
      step(4'd6,  4'd5,  2'b01, 16'd1,  1'b0, "sub_6_5");
      step(4'd2,  4'd9,  2'b01, 16'd9,  1'b1, "sub_2_9");
      step(4'd5,  4'd5,  2'b01, 16'd0,  1'b0, "sub_5_5");

      // Multiply
      step(4'd6,  4'd5,  2'b10, 16'd30,  1'b0, "mul_6_5");
      step(4'd15, 4'd15, 2'b10, 16'd225, 1'b0, "mul_15_15");
      step(4'd12, 4'd12, 2'b10, 16'h0090, 1'b0, "mul_12_12");

      // Divide
      step(4'd8,  4'd7,  2'b11, 16'h0101, 1'b0, "div_8_7");
      step(4'd9,  4'd10, 2'b11, 16'h0900, 1'b0, "div_9_10");
      step(4'd5,  4'd0,  2'b11, 16'h050F, 1'b1, "div_5_0");
      step(4'd15, 4'd4,  2'b11, 16'h0303, 1'b0, "div_15_4");
      step(4'd15, 4'd1,  2'b11, 16'h000F, 1'b0, "div_15_1");

      // Latency: new inputs before the edge leave the old result visible
      A = 4'd1; B = 4'd2; Sel = 2'b00;
      #1;
      check("lat_before_edge", 16'h000F, 1'b0);
      @(posedge clk);
      #1;
      check("lat_after_edge", 16'd3, 1'b0);

      // Inputs changed between edges have no effect until the next edge
      #2;
      A = 4'd4; B = 4'd4; Sel = 2'b10;
      #1;
      check("mid_cycle_hold", 16'd3, 1'b0);
      @(posedge clk);
      #1;
      check("mid_cycle_capture", 16'd16, 1'b0);

      // Async reset pulse between edges, with a nonzero result and flag held
      step(4'd0, 4'd0, 2'b11, 16'h000F, 1'b1, "div_0_0");
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_immediate", 16'h0000, 1'b0);
      rst = 1'b0;
      #1;
      check("async_reset_no_recovery", 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      check("after_async_reset", 16'h000F, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
